// File: rtl/dpc_frame_source.sv
// dpc_frame_source: reads one frame from a synchronous frame memory in raster
// order and streams it as an AXI4-Stream pixel channel plus a paired k channel.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   start                one-cycle pulse, begins a frame (ignored while busy)
//   busy                 frame in progress, through the frame_done cycle
//   frame_done           one-cycle pulse after the final beat handshake
//   mem_rd_en/addr       read strobe and address (row*FRAME_WIDTH+col)
//   mem_rd_pix/k         read data, valid the cycle after mem_rd_en
//   m_axis_*             pixel stream (tuser = start of frame, tlast = end of line)
//   k_axis_*             k stream, no backpressure, beat-locked to m_axis
module dpc_frame_source #(
  parameter int WIDTH        = 16,
  parameter int K_WIDTH      = 16,
  parameter int FRAME_WIDTH  = 10,
  parameter int FRAME_HEIGHT = 10,
  parameter int ADDR_WIDTH   = 20,
  parameter int LINE_GAP     = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]      mem_rd_pix,
  input  logic [K_WIDTH-1:0]    mem_rd_k,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [WIDTH-1:0]      m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  k_axis_tvalid,
  output logic [K_WIDTH-1:0]    k_axis_tdata
);

  localparam int CW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int RW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [CW-1:0] ColLast = CW'(FRAME_WIDTH - 1);
  localparam logic [RW-1:0] RowLast = RW'(FRAME_HEIGHT - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StActive = 2'd1;
  localparam logic [1:0] StGap    = 2'd2;
  localparam logic [1:0] StDrain  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  start_q, start_d;
  logic                  done_q, done_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           gap_q, gap_d;

  // Read issued last cycle; its data and beat tags arrive this cycle.
  logic                  infl_q;
  logic                  infl_user_q, infl_last_q;

  // Two-entry output buffer.
  logic [WIDTH-1:0]      pix_q [2];
  logic [K_WIDTH-1:0]    k_q   [2];
  logic [1:0]            user_q, last_q;
  logic                  wp_q, rp_q;
  logic [1:0]            cnt_q, cnt_d;

  logic                  push, pop, rd_issue, last_pop;
  logic [1:0]            credit_used;

  assign push = infl_q;
  assign pop  = m_axis_tvalid && m_axis_tready;

  // Credits count the occupancy left after this cycle's pop, so a full-rate
  // stream keeps one beat buffered and one read in flight without a bubble.
  assign credit_used = cnt_q - {1'b0, pop} + {1'b0, infl_q};
  assign rd_issue    = (state_q == StActive) && (credit_used < 2'd2);

  // Final beat leaves the buffer with nothing behind it.
  assign last_pop = (state_q == StDrain) && pop && (cnt_q == 2'd1) && !infl_q;

  assign busy        = start_q || (state_q != StIdle) || done_q;
  assign frame_done  = done_q;
  assign mem_rd_en   = rd_issue;
  assign mem_rd_addr = addr_q;

  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign m_axis_tdata  = pix_q[rp_q];
  assign m_axis_tuser  = user_q[rp_q];
  assign m_axis_tlast  = last_q[rp_q];
  assign k_axis_tvalid = m_axis_tvalid;
  assign k_axis_tdata  = k_q[rp_q];

  always_comb begin
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    done_d  = 1'b0;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    gap_d   = gap_q;
    if (start && !busy) start_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start_q) begin
          start_d = 1'b0;
          state_d = StActive;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
        end
      end
      StActive: begin
        if (rd_issue) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (col_q == ColLast) begin
            col_d = '0;
            if (row_q == RowLast) begin
              state_d = StDrain;
            end else begin
              row_d = row_q + RW'(1);
              if (LINE_GAP > 0) begin
                state_d = StGap;
                gap_d   = '0;
              end
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      StGap: begin
        // Count only once the line's tlast beat has left, so the idle time is
        // seen on the stream even when downstream stalls the end of a line.
        if ((cnt_q == 2'd0) && !infl_q) begin
          if (gap_q == 16'(LINE_GAP - 1)) state_d = StActive;
          else gap_d = gap_q + 16'd1;
        end
      end
      StDrain: begin
        if (last_pop) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      gap_q       <= '0;
      infl_q      <= 1'b0;
      infl_user_q <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      done_q      <= done_d;
      col_q       <= col_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      gap_q       <= gap_d;
      infl_q      <= rd_issue;
      if (rd_issue) begin
        infl_user_q <= (row_q == '0) && (col_q == '0);
        infl_last_q <= (col_q == ColLast);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 2; i++) begin
        pix_q[i] <= '0;
        k_q[i]   <= '0;
      end
      user_q <= '0;
      last_q <= '0;
      wp_q   <= 1'b0;
      rp_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        pix_q[wp_q]  <= mem_rd_pix;
        k_q[wp_q]    <= mem_rd_k;
        user_q[wp_q] <= infl_user_q;
        last_q[wp_q] <= infl_last_q;
        wp_q         <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dpc_frame_source.sv
module tb_dpc_frame_source;

  localparam int NPix = 100;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic sel = 1'b0;
  logic mon_en = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Two instances: LINE_GAP=0 (sel=0) and LINE_GAP=3 (sel=1).
  logic        busy0, done0, rd0, tv0, tu0, tl0, kv0;
  logic [19:0] addr0;
  logic [15:0] td0, kd0, mpix0, mk0;
  logic        busy1, done1, rd1, tv1, tu1, tl1, kv1;
  logic [19:0] addr1;
  logic [15:0] td1, kd1, mpix1, mk1;
  logic        start0, start1;
  assign start0 = start && !sel;
  assign start1 = start && sel;

  function automatic logic [15:0] pix_of(input logic [19:0] a);
    int r, c;
    r = int'(a) / 10;
    c = int'(a) % 10;
    return 16'(1000 + 100 * r + 10 * c);
  endfunction

  always @(posedge clk) begin
    if (rd0) begin
      mpix0 <= pix_of(addr0);
      mk0   <= pix_of(addr0) + 16'd7;
    end
    if (rd1) begin
      mpix1 <= pix_of(addr1);
      mk1   <= pix_of(addr1) + 16'd7;
    end
  end

  dpc_frame_source #(.LINE_GAP(0)) u_dut (
    .aclk(clk), .aresetn(aresetn), .start(start0), .busy(busy0), .frame_done(done0),
    .mem_rd_en(rd0), .mem_rd_addr(addr0), .mem_rd_pix(mpix0), .mem_rd_k(mk0),
    .m_axis_tvalid(tv0), .m_axis_tready(ready), .m_axis_tdata(td0), .m_axis_tuser(tu0),
    .m_axis_tlast(tl0), .k_axis_tvalid(kv0), .k_axis_tdata(kd0)
  );

  dpc_frame_source #(.LINE_GAP(3)) u_dut_gap (
    .aclk(clk), .aresetn(aresetn), .start(start1), .busy(busy1), .frame_done(done1),
    .mem_rd_en(rd1), .mem_rd_addr(addr1), .mem_rd_pix(mpix1), .mem_rd_k(mk1),
    .m_axis_tvalid(tv1), .m_axis_tready(ready), .m_axis_tdata(td1), .m_axis_tuser(tu1),
    .m_axis_tlast(tl1), .k_axis_tvalid(kv1), .k_axis_tdata(kd1)
  );

  logic        busy, fdone, rd_en, tvalid, tuser, tlast, ktvalid;
  logic [19:0] addr;
  logic [15:0] tdata, ktdata;
  assign busy    = sel ? busy1 : busy0;
  assign fdone   = sel ? done1 : done0;
  assign rd_en   = sel ? rd1 : rd0;
  assign addr    = sel ? addr1 : addr0;
  assign tvalid  = sel ? tv1 : tv0;
  assign tuser   = sel ? tu1 : tu0;
  assign tlast   = sel ? tl1 : tl0;
  assign tdata   = sel ? td1 : td0;
  assign ktvalid = sel ? kv1 : kv0;
  assign ktdata  = sel ? kd1 : kd0;

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] pix;
    logic        user;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  // Monitor state, written only by the monitor.
  int          beat_cnt = 0;
  int          done_cnt = 0;
  int          rd_cnt = 0;
  int          gap_checks = 0;
  int          gap_low = 0;
  bit          gap_cnting = 0;
  bit          done_exp = 0;
  bit          stall_prev = 0;
  logic [33:0] hold_val = '0;
  int unsigned first_cyc = 0;
  int unsigned last_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!mon_en) begin
      stall_prev = 0;
      done_exp   = 0;
      gap_cnting = 0;
      rd_cnt     = 0;
      exp_q.delete();
    end else begin
      check_val("k_tvalid", ktvalid, tvalid);
      check_val("frame_done", fdone, done_exp);
      done_exp = 0;
      if (fdone) begin
        done_cnt++;
        rd_cnt = 0;
      end
      if (stall_prev) check_val("stall_hold", {tdata, ktdata, tuser, tlast}, hold_val);
      if (rd_en) begin
        check_val("rd_addr", addr, rd_cnt);
        rd_cnt++;
      end
      if (gap_cnting) begin
        if (!tvalid) gap_low++;
        else begin
          check_val("line_gap", gap_low >= 3, 1);
          gap_checks++;
          gap_cnting = 0;
        end
      end
      if (tvalid && ready) begin
        if (exp_q.size() == 0) begin
          check_val("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("tdata", tdata, e.pix);
          check_val("tuser", tuser, e.user);
          check_val("tlast", tlast, e.last);
          check_val("k_tdata", ktdata, tdata + 16'd7);
          beat_cnt++;
          if (e.user) first_cyc = cyc;
          last_cyc = cyc;
          if (exp_q.size() == 0) done_exp = 1;
          else if (sel && tlast) begin
            gap_cnting = 1;
            gap_low    = 0;
          end
        end
      end
      stall_prev = tvalid && !ready;
      hold_val   = {tdata, ktdata, tuser, tlast};
    end
  end

  task automatic run_frame();
    exp_t e;
    for (int a = 0; a < NPix; a++) begin
      e.pix  = pix_of(20'(a));
      e.user = (a == 0);
      e.last = ((a % 10) == 9);
      exp_q.push_back(e);
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int base_done, input bit tog);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (done_cnt != base_done) break;
      if (tog) ready = !ready;
    end
    check_val("frame_timeout", done_cnt - base_done, 1);
  endtask

  int bb, bd, bg;
  bit pulsed;

  initial begin
    // Reset state
    #12;
    check_val("reset_outputs", {tv0, td0, tu0, tl0, kv0, kd0, rd0, addr0, busy0, done0}, 0);
    check_val("reset_outputs_gap", {tv1, td1, tu1, tl1, kv1, kd1, rd1, addr1, busy1, done1}, 0);
    @(posedge clk); #1 aresetn = 1'b1; mon_en = 1'b1;

    // Full-rate ramp frame with first-beat latency checks
    ready = 1'b1;
    bb = beat_cnt; bd = done_cnt;
    run_frame();
    @(negedge clk);
    check_val("busy_e0", busy, 1);
    check_val("rd_en_e0", rd_en, 0);
    @(negedge clk);
    check_val("rd_en_e1", {rd_en, addr}, {1'b1, 20'd0});
    @(negedge clk);
    check_val("tvalid_e2", tvalid, 0);
    @(negedge clk);
    check_val("first_beat_e3", {tvalid, tdata, tuser}, {1'b1, 16'd1000, 1'b1});
    wait_done(bd, 0);
    check_val("beats_f1", beat_cnt - bb, NPix);
    check_val("contiguous", last_cyc - first_cyc, NPix - 1);
    @(negedge clk);
    check_val("busy_after_done", busy, 0);

    // Toggled ready
    bb = beat_cnt; bd = done_cnt;
    run_frame();
    wait_done(bd, 1);
    check_val("beats_toggle", beat_cnt - bb, NPix);

    // Long stall on the first beat
    ready = 1'b0;
    bb = beat_cnt; bd = done_cnt;
    run_frame();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tvalid) break;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("stall_tvalid", {tvalid, tdata}, {1'b1, 16'd1000});
    end
    check_val("stall_reads", (rd_cnt - (beat_cnt - bb)) <= 2, 1);
    @(posedge clk); #1 ready = 1'b1;
    wait_done(bd, 0);
    check_val("beats_stall", beat_cnt - bb, NPix);

    // Line gap instance
    @(posedge clk); #1 sel = 1'b1;
    bb = beat_cnt; bd = done_cnt; bg = gap_checks;
    run_frame();
    wait_done(bd, 0);
    check_val("beats_gap", beat_cnt - bb, NPix);
    check_val("gap_count", gap_checks - bg, 9);
    @(posedge clk); #1 sel = 1'b0;

    // Second start during a frame is ignored
    bb = beat_cnt; bd = done_cnt; pulsed = 0;
    run_frame();
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done_cnt != bd) break;
      if (!pulsed && (beat_cnt - bb) >= 50) begin
        start = 1'b1;
        pulsed = 1;
      end
    end
    start = 1'b0;
    check_val("frame_timeout_restart", done_cnt - bd, 1);
    repeat (10) @(posedge clk);
    #1;
    check_val("no_refire", {beat_cnt - bb, 31'(busy)}, {NPix, 31'd0});

    // Reset mid-frame after beat 37
    bb = beat_cnt; bd = done_cnt;
    run_frame();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if ((beat_cnt - bb) >= 37) break;
    end
    aresetn = 1'b0; mon_en = 1'b0;
    #1;
    check_val("abort_outputs", {tv0, td0, tu0, tl0, kv0, kd0, rd0, addr0, busy0, done0}, 0);
    @(posedge clk); #1 aresetn = 1'b1;
    @(posedge clk); #1 mon_en = 1'b1;
    bb = beat_cnt;
    repeat (20) @(posedge clk);
    #1;
    check_val("abort_quiet", {beat_cnt - bb, done_cnt - bd}, 0);

    // Fresh frame after abort
    bb = beat_cnt; bd = done_cnt;
    run_frame();
    wait_done(bd, 0);
    check_val("beats_fresh", beat_cnt - bb, NPix);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
